usb_utmi_linemon: RTL
=====================

USB_UTMI_LINEMON -- requirements
Module: usb_utmi_linemon

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 150, meaning consecutive SE0 samples that signal bus reset (2.5 us at 60 MHz).
REQ-002 SHALL have parameter SUSPEND_CYCLES, default 180000, meaning consecutive J samples that signal suspend (3 ms at 60 MHz).
REQ-003 SHALL have parameter RESUME_CYCLES, default 150, meaning consecutive K samples in suspend that signal resume.
REQ-004 Ports: clk  in  1  the only clock, UTMI 60 MHz.
REQ-005 Ports: rst  in  1  reset, synchronous and active-high.
REQ-006 Ports: line_state  in  2  utmi_line_state_t from the PHY, may change asynchronously to clk.
REQ-007 Ports: bus_reset  out  1  single-cycle pulse on bus-reset detection.
REQ-008 Ports: reset_active  out  1  level, high while the bus-reset condition persists.
REQ-009 Ports: suspend  out  1  level, high while suspended.
REQ-010 Ports: resume  out  1  single-cycle pulse on resume detection.

Function
REQ-011 line_state SHALL pass a 2-flop synchronizer; the output ls_s is the "sample" in all rules below.
REQ-012 One saturating run counter SHALL count consecutive cycles in which ls_s equals the previous ls_s; any change of ls_s reloads it to 1.
REQ-013 Counter width SHALL be $clog2(max(RESET_CYCLES, SUSPEND_CYCLES, RESUME_CYCLES)+1); it SHALL saturate, never wrap.
REQ-014 States: ACTIVE, BUS_RESET, SUSPEND, RESUME.
REQ-015 ACTIVE -> BUS_RESET when ls_s==SE0 and run count reaches RESET_CYCLES.
REQ-016 ACTIVE -> SUSPEND when ls_s==DJ and run count reaches SUSPEND_CYCLES.
REQ-017 BUS_RESET -> ACTIVE on the first sample with ls_s!=SE0.
REQ-018 SUSPEND -> RESUME when ls_s==DK and run count reaches RESUME_CYCLES.
REQ-019 SUSPEND -> BUS_RESET when ls_s==SE0 and run count reaches RESET_CYCLES; reset takes priority and suspend SHALL deassert.
REQ-020 RESUME -> ACTIVE on the first sample with ls_s==DJ, or with ls_s==SE0 (EOP).
REQ-021 SE1 SHALL be treated as noise: the run restarts and no state transition occurs.
REQ-022 bus_reset and resume SHALL be registered and high for exactly the one cycle after the qualifying transition; reset_active and suspend SHALL be registered decodes of state.
REQ-023 Latency: bus_reset SHALL be high 3 cycles after the RESET_CYCLES-th SE0 cycle at the line_state port (2 sync + 1 register); the same latency SHALL apply to suspend and resume.
REQ-024 A run shorter than its threshold by one cycle SHALL cause no transition.

Reset
REQ-025 While rst is high: state=ACTIVE, counter=0, synchronizer flops=DJ, and all outputs=0.
REQ-026 rst asserted mid-reset or mid-suspend SHALL return the block to ACTIVE on the next edge, with no output pulse generated.

Structure
REQ-027 utmi_linemon_state_t and the default cycle constants SHALL be placed in usb_utmi_pkg alongside utmi_line_state_t.
REQ-028 The synchronizer SHALL be a sub-module usb_sync2 (2-flop, width parameter, reset value parameter); the FSM and counter SHALL be inline.

Verification (RESET_CYCLES=8, SUSPEND_CYCLES=32, RESUME_CYCLES=4)
REQ-029 Drive SE0 for 8 cycles from DJ -> bus_reset single pulse 3 cycles after the 8th; reset_active high until 3 cycles after DJ returns.
REQ-030 Drive SE0 for 7 cycles, then DJ -> no bus_reset, reset_active stays 0.
REQ-031 Drive DJ for 32 cycles -> suspend=1; then DK for 4 cycles -> resume pulse, suspend=0; then SE0 then DJ -> state ACTIVE.
REQ-032 While in suspend, drive SE0 for 8 cycles -> suspend=0, bus_reset pulse, reset_active=1.
REQ-033 Drive DJ 20 cycles, SE1 1 cycle, DJ 20 cycles -> suspend never asserts (run restarted).
REQ-034 Assert rst during reset_active=1 -> all outputs 0 on the next cycle; after rst releases, a 32-cycle DJ run is required to reach suspend.

Source files
------------

// File: rtl/usb_utmi_pkg.sv
// rtl/usb_utmi_pkg.sv - UTMI line-state types, line monitor states and default timing constants
package usb_utmi_pkg;

    // UTMI LineState encoding as delivered by the PHY.
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_DJ  = 2'b01,
        LS_DK  = 2'b10,
        LS_SE1 = 2'b11
    } utmi_line_state_t;

    // Bus condition tracked by the line monitor.
    typedef enum logic [1:0] {
        LM_ACTIVE    = 2'b00,
        LM_BUS_RESET = 2'b01,
        LM_SUSPEND   = 2'b10,
        LM_RESUME    = 2'b11
    } utmi_linemon_state_t;

    // Default thresholds in 60 MHz UTMI clock cycles.
    localparam int DEF_RESET_CYCLES   = 150;     // 2.5 us of SE0
    localparam int DEF_SUSPEND_CYCLES = 180000;  // 3 ms of idle J
    localparam int DEF_RESUME_CYCLES  = 150;     // K run that ends suspend

    // Largest of three thresholds; sizes the shared run counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/usb_sync2.sv
// rtl/usb_sync2.sv - two-flop synchronizer with configurable width and reset value
module usb_sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the asynchronous input into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/usb_utmi_linemon.sv
// rtl/usb_utmi_linemon.sv - UTMI line-state monitor detecting bus reset, suspend and resume
module usb_utmi_linemon
    import usb_utmi_pkg::*;
#(
    parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int SUSPEND_CYCLES = DEF_SUSPEND_CYCLES,
    parameter int RESUME_CYCLES  = DEF_RESUME_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] line_state,
    output logic       bus_reset,
    output logic       reset_active,
    output logic       suspend,
    output logic       resume
);

    localparam int RUN_W = $clog2(max3(RESET_CYCLES, SUSPEND_CYCLES, RESUME_CYCLES) + 1);

    localparam logic [RUN_W-1:0] RUN_SAT    = '1;
    localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);
    localparam logic [RUN_W-1:0] RESET_TH   = RUN_W'(RESET_CYCLES);
    localparam logic [RUN_W-1:0] SUSPEND_TH = RUN_W'(SUSPEND_CYCLES);
    localparam logic [RUN_W-1:0] RESUME_TH  = RUN_W'(RESUME_CYCLES);

    logic [1:0]          ls_raw;
    utmi_line_state_t    ls_s;
    utmi_line_state_t    prev_q;
    logic [RUN_W-1:0]    run_q, run_d;
    utmi_linemon_state_t state_q, state_d;
    logic                bus_reset_q, reset_active_q, suspend_q, resume_q;
    logic                enter_reset, enter_resume;

    usb_sync2 #(
        .WIDTH     (2),
        .RESET_VAL (LS_DJ)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (line_state),
        .q_o (ls_raw)
    );

    assign ls_s = utmi_line_state_t'(ls_raw);

    // Run length of the current sample value, including this cycle; saturates at all-ones.
    always_comb begin
        run_d = RUN_ONE;
        if (ls_s == prev_q) begin
            run_d = (run_q == RUN_SAT) ? run_q : run_q + RUN_ONE;
        end
    end

    // Next bus condition; SE1 never qualifies any move, so it only restarts the run.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LM_ACTIVE: begin
                if (ls_s == LS_SE0 && run_d >= RESET_TH)
                    state_d = LM_BUS_RESET;
                else if (ls_s == LS_DJ && run_d >= SUSPEND_TH)
                    state_d = LM_SUSPEND;
            end
            LM_BUS_RESET: begin
                if (ls_s == LS_DJ || ls_s == LS_DK)
                    state_d = LM_ACTIVE;
            end
            LM_SUSPEND: begin
                if (ls_s == LS_SE0 && run_d >= RESET_TH)
                    state_d = LM_BUS_RESET;
                else if (ls_s == LS_DK && run_d >= RESUME_TH)
                    state_d = LM_RESUME;
            end
            LM_RESUME: begin
                if (ls_s == LS_DJ || ls_s == LS_SE0)
                    state_d = LM_ACTIVE;
            end
            default: state_d = LM_ACTIVE;
        endcase
    end

    assign enter_reset  = (state_d == LM_BUS_RESET) && (state_q != LM_BUS_RESET);
    assign enter_resume = (state_d == LM_RESUME) && (state_q == LM_SUSPEND);

    // State, run counter and registered outputs; reset silences all outputs at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= LM_ACTIVE;
            prev_q         <= LS_DJ;
            run_q          <= '0;
            bus_reset_q    <= 1'b0;
            reset_active_q <= 1'b0;
            suspend_q      <= 1'b0;
            resume_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_q         <= ls_s;
            run_q          <= run_d;
            bus_reset_q    <= enter_reset;
            reset_active_q <= (state_d == LM_BUS_RESET);
            suspend_q      <= (state_d == LM_SUSPEND);
            resume_q       <= enter_resume;
        end
    end

    assign bus_reset    = bus_reset_q;
    assign reset_active = reset_active_q;
    assign suspend      = suspend_q;
    assign resume       = resume_q;

endmodule
